// File: rtl/scr1_dmi_dm_bridge_pkg.sv
// Shared types for the DMI-to-DM bridge: FSM state encoding, sticky status codes
// and the status update rule.
package scr1_dmi_dm_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } type_scr1_dmi_brg_fsm_e;

   localparam logic [1:0] SCR1_DMI_STAT_OK   = 2'b00;
   localparam logic [1:0] SCR1_DMI_STAT_FAIL = 2'b10;
   localparam logic [1:0] SCR1_DMI_STAT_BUSY = 2'b11;

   // First error is sticky; a clear in the same cycle as a new error loses to the error.
   function automatic logic [1:0] scr1_dmi_stat_next(
      input logic [1:0] cur,
      input logic       clr,
      input logic       busy_err,
      input logic       fail_err
   );
      logic [1:0] base;
      base = clr ? SCR1_DMI_STAT_OK : cur;
      if (busy_err && (base == SCR1_DMI_STAT_OK)) return SCR1_DMI_STAT_BUSY;
      if (fail_err && (base == SCR1_DMI_STAT_OK)) return SCR1_DMI_STAT_FAIL;
      return base;
   endfunction

endpackage

// File: rtl/scr1_dmi_bridge_tmr.sv
// REQ-phase timeout counter for the DMI-to-DM bridge; built only when
// SCR1_DMI_BRIDGE_TIMEOUT_EN is defined.
module scr1_dmi_bridge_tmr #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Saturates at LIMIT; the bridge leaves REQ on the expiring cycle anyway.
   always_ff @(posedge clk) begin
      if (rst || start) begin
         cnt <= '0;
      end else if (run && !expire) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = (cnt == LIMIT);

endmodule

// File: rtl/scr1_dmi_dm_bridge.sv
// Registered request/response stage between the DMI and the Debug Module.
// Optional REQ timeout enabled by defining SCR1_DMI_BRIDGE_TIMEOUT_EN.
module scr1_dmi_dm_bridge
   import scr1_dmi_dm_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH     = 7,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dmi_req_i,
   input  logic                  dmi_wr_i,
   input  logic [ADDR_WIDTH-1:0] dmi_addr_i,
   input  logic [DATA_WIDTH-1:0] dmi_wdata_i,
   input  logic                  dmi_stat_clr_i,
   output logic                  dmi_resp_o,
   output logic [DATA_WIDTH-1:0] dmi_rdata_o,
   output logic                  dmi_busy_o,
   output logic [1:0]            dmi_stat_o,
   output logic                  dm_req_o,
   output logic                  dm_wr_o,
   output logic [ADDR_WIDTH-1:0] dm_addr_o,
   output logic [DATA_WIDTH-1:0] dm_wdata_o,
   input  logic                  dm_resp_i,
   input  logic [DATA_WIDTH-1:0] dm_rdata_i
);

   type_scr1_dmi_brg_fsm_e state;

   logic req_accept;
   logic overrun;
   logic resp_ok;
   logic timeout;

   assign req_accept = dmi_req_i && (state == IDLE);
   assign overrun    = dmi_req_i && (state != IDLE);
   assign resp_ok    = dm_resp_i && (state == REQ);

`ifdef SCR1_DMI_BRIDGE_TIMEOUT_EN
   logic tmr_expire;

   scr1_dmi_bridge_tmr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) i_tmr (
      .clk    (clk),
      .rst    (rst),
      .start  (req_accept),
      .run    ((state == REQ) && !dm_resp_i),
      .expire (tmr_expire)
   );

   // A response in the expiring cycle completes normally.
   assign timeout = (state == REQ) && !dm_resp_i && tmr_expire;
`else
   // No counter in this build; the parameter stays referenced but has no effect.
   assign timeout = 1'b0 & (TIMEOUT_CYCLES < 2);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dmi_resp_o  <= 1'b0;
         dmi_rdata_o <= '0;
         dmi_busy_o  <= 1'b0;
         dmi_stat_o  <= SCR1_DMI_STAT_OK;
         dm_req_o    <= 1'b0;
         dm_wr_o     <= 1'b0;
         dm_addr_o   <= '0;
         dm_wdata_o  <= '0;
      end else begin
         dmi_resp_o <= 1'b0;
         dmi_stat_o <= scr1_dmi_stat_next(dmi_stat_o, dmi_stat_clr_i, overrun, timeout);
         case (state)
            IDLE: begin
               if (dmi_req_i) begin
                  state      <= REQ;
                  dm_req_o   <= 1'b1;
                  dmi_busy_o <= 1'b1;
                  dm_wr_o    <= dmi_wr_i;
                  dm_addr_o  <= dmi_addr_i;
                  dm_wdata_o <= dmi_wdata_i;
               end
            end
            REQ: begin
               if (resp_ok || timeout) begin
                  state      <= DONE;
                  dm_req_o   <= 1'b0;
                  dmi_resp_o <= 1'b1;
                  if (resp_ok && !dm_wr_o) begin
                     dmi_rdata_o <= dm_rdata_i;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               dmi_busy_o <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               dm_req_o   <= 1'b0;
               dmi_busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scr1_dmi_dm_bridge.sv
// Scoreboard bench for scr1_dmi_dm_bridge; the timeout scenarios are compiled in
// only when SCR1_DMI_BRIDGE_TIMEOUT_EN is defined.
module tb_scr1_dmi_dm_bridge;
   import scr1_dmi_dm_bridge_pkg::*;

   localparam int AW = 7;
   localparam int DW = 32;
   localparam int TC = 4;

   logic          clk;
   logic          rst;
   logic          dmi_req_i;
   logic          dmi_wr_i;
   logic [AW-1:0] dmi_addr_i;
   logic [DW-1:0] dmi_wdata_i;
   logic          dmi_stat_clr_i;
   logic          dmi_resp_o;
   logic [DW-1:0] dmi_rdata_o;
   logic          dmi_busy_o;
   logic [1:0]    dmi_stat_o;
   logic          dm_req_o;
   logic          dm_wr_o;
   logic [AW-1:0] dm_addr_o;
   logic [DW-1:0] dm_wdata_o;
   logic          dm_resp_i;
   logic [DW-1:0] dm_rdata_i;

   scr1_dmi_dm_bridge #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .dmi_req_i      (dmi_req_i),
      .dmi_wr_i       (dmi_wr_i),
      .dmi_addr_i     (dmi_addr_i),
      .dmi_wdata_i    (dmi_wdata_i),
      .dmi_stat_clr_i (dmi_stat_clr_i),
      .dmi_resp_o     (dmi_resp_o),
      .dmi_rdata_o    (dmi_rdata_o),
      .dmi_busy_o     (dmi_busy_o),
      .dmi_stat_o     (dmi_stat_o),
      .dm_req_o       (dm_req_o),
      .dm_wr_o        (dm_wr_o),
      .dm_addr_o      (dm_addr_o),
      .dm_wdata_o     (dm_wdata_o),
      .dm_resp_i      (dm_resp_i),
      .dm_rdata_i     (dm_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic [1:0]  stat;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int c, input logic [31:0] rd, input logic [1:0] st);
      exp_t e;
      e.cyc   = c;
      e.rdata = rd;
      e.stat  = st;
      q.push_back(e);
   endtask

   // Monitor: every response pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (dmi_resp_o === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got dmi_resp_o=1 expected none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            chk("resp_rdata", dmi_rdata_o, e.rdata);
            chk("resp_stat", {30'd0, dmi_stat_o}, {30'd0, e.stat});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within bound");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      dmi_req_i   = 1'b1;
      dmi_wr_i    = wr;
      dmi_addr_i  = addr;
      dmi_wdata_i = wd;
      step();
      dmi_req_i = 1'b0;
      chk("req_dm_req", {31'd0, dm_req_o}, 32'd1);
      chk("req_dm_addr", {25'd0, dm_addr_o}, {25'd0, addr});
      chk("req_dm_wr", {31'd0, dm_wr_o}, {31'd0, wr});
      chk("req_dm_wdata", dm_wdata_o, wd);
      chk("req_busy", {31'd0, dmi_busy_o}, 32'd1);
   endtask

   // Respond now; the response pulse is expected on the next cycle, then back to IDLE.
   task automatic dm_respond(input logic [DW-1:0] rd, input logic [DW-1:0] exp_rd,
                             input logic [1:0] exp_st);
      dm_resp_i  = 1'b1;
      dm_rdata_i = rd;
      push_exp(cyc + 1, exp_rd, exp_st);
      step();
      dm_resp_i  = 1'b0;
      dm_rdata_i = '0;
      chk("done_dm_req_low", {31'd0, dm_req_o}, 32'd0);
      step();
      chk("idle_busy_low", {31'd0, dmi_busy_o}, 32'd0);
   endtask

   task automatic stat_clear();
      dmi_stat_clr_i = 1'b1;
      step();
      dmi_stat_clr_i = 1'b0;
      chk("stat_cleared", {30'd0, dmi_stat_o}, 32'd0);
   endtask

   initial begin
      int q0;
      rst            = 1'b1;
      dmi_req_i      = 1'b0;
      dmi_wr_i       = 1'b0;
      dmi_addr_i     = '0;
      dmi_wdata_i    = '0;
      dmi_stat_clr_i = 1'b0;
      dm_resp_i      = 1'b0;
      dm_rdata_i     = '0;
      repeat (3) step();
      chk("rst_resp", {31'd0, dmi_resp_o}, 32'd0);
      chk("rst_rdata", dmi_rdata_o, 32'd0);
      chk("rst_busy", {31'd0, dmi_busy_o}, 32'd0);
      chk("rst_stat", {30'd0, dmi_stat_o}, 32'd0);
      chk("rst_dm_req", {31'd0, dm_req_o}, 32'd0);
      chk("rst_dm_wr", {31'd0, dm_wr_o}, 32'd0);
      chk("rst_dm_addr", {25'd0, dm_addr_o}, 32'd0);
      chk("rst_dm_wdata", dm_wdata_o, 32'd0);
      rst = 1'b0;
      step();

      // 1: read 0x11, DM answers in the first REQ cycle
      do_req(1'b0, 7'h11, 32'h0);
      dm_respond(32'hDEADBEEF, 32'hDEADBEEF, SCR1_DMI_STAT_OK);

      // 2: read A5A5A5A5, then a write held five cycles; rdata must not change
      do_req(1'b0, 7'h05, 32'h0);
      dm_respond(32'hA5A5A5A5, 32'hA5A5A5A5, SCR1_DMI_STAT_OK);
      do_req(1'b1, 7'h10, 32'h1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("wr_hold_req", {31'd0, dm_req_o}, 32'd1);
         chk("wr_hold_addr", {25'd0, dm_addr_o}, 32'h10);
         chk("wr_hold_wdata", dm_wdata_o, 32'h1);
      end
      dm_respond(32'h12345678, 32'hA5A5A5A5, SCR1_DMI_STAT_OK);
      chk("idle_addr_held", {25'd0, dm_addr_o}, 32'h10);

      // dm_resp_i while idle is ignored
      dm_resp_i  = 1'b1;
      dm_rdata_i = 32'hFFFFFFFF;
      step();
      dm_resp_i  = 1'b0;
      dm_rdata_i = '0;
      step();
      chk("idle_resp_ignored", dmi_rdata_o, 32'hA5A5A5A5);
      chk("idle_resp_busy", {31'd0, dmi_busy_o}, 32'd0);

      // 3: overrun while in REQ
      do_req(1'b0, 7'h20, 32'h0);
      q0 = cyc;
      dmi_req_i   = 1'b1;
      dmi_wr_i    = 1'b1;
      dmi_addr_i  = 7'h33;
      dmi_wdata_i = 32'h55;
      step();
      dmi_req_i = 1'b0;
      chk("ovr_addr_kept", {25'd0, dm_addr_o}, 32'h20);
      chk("ovr_wr_kept", {31'd0, dm_wr_o}, 32'd0);
      chk("ovr_stat", {30'd0, dmi_stat_o}, 32'h3);
      chk("ovr_still_req", {31'd0, dm_req_o}, 32'd1);
`ifdef SCR1_DMI_BRIDGE_TIMEOUT_EN
      push_exp(q0 + TC, 32'hA5A5A5A5, SCR1_DMI_STAT_BUSY);
      repeat (TC) step();
      chk("ovr_to_idle", {31'd0, dmi_busy_o}, 32'd0);
`else
      dm_respond(32'hCAFEF00D, 32'hCAFEF00D, SCR1_DMI_STAT_BUSY);
`endif
      stat_clear();

      // 4: reset in REQ drops the transaction
      do_req(1'b0, 7'h07, 32'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstreq_dm_req", {31'd0, dm_req_o}, 32'd0);
      chk("rstreq_busy", {31'd0, dmi_busy_o}, 32'd0);
      chk("rstreq_resp", {31'd0, dmi_resp_o}, 32'd0);
      chk("rstreq_rdata", dmi_rdata_o, 32'd0);
      repeat (2) step();
      do_req(1'b0, 7'h03, 32'h0);
      dm_respond(32'h0BADF00D, 32'h0BADF00D, SCR1_DMI_STAT_OK);

`ifdef SCR1_DMI_BRIDGE_TIMEOUT_EN
      // 5: DM silent -> timeout after TC REQ cycles; then response in the last REQ cycle
      do_req(1'b0, 7'h04, 32'h0);
      q0 = cyc;
      push_exp(q0 + TC, 32'h0BADF00D, SCR1_DMI_STAT_FAIL);
      for (int i = 0; i < TC - 1; i++) begin
         chk("to_wait_req", {31'd0, dm_req_o}, 32'd1);
         step();
      end
      chk("to_last_req", {31'd0, dm_req_o}, 32'd1);
      step();
      step();
      chk("to_idle", {31'd0, dmi_busy_o}, 32'd0);
      stat_clear();
      do_req(1'b0, 7'h04, 32'h0);
      repeat (TC - 1) step();
      dm_respond(32'h13579BDF, 32'h13579BDF, SCR1_DMI_STAT_OK);
`endif

      // 6: clear coincident with overrun, error wins
      do_req(1'b0, 7'h12, 32'h0);
      dmi_req_i      = 1'b1;
      dmi_stat_clr_i = 1'b1;
      step();
      dmi_req_i      = 1'b0;
      dmi_stat_clr_i = 1'b0;
      chk("clr_vs_ovr_stat", {30'd0, dmi_stat_o}, 32'h3);
      dm_respond(32'h600DCAFE, 32'h600DCAFE, SCR1_DMI_STAT_BUSY);
      stat_clear();

      repeat (5) step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_resp: got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
